tipi_rpi_link: RTL and testbench

TIPI_RPI_LINK -- requirements
Module: tipi_rpi_link

---
 rtl/tipi_rpi_link.sv | 162 ++++++++++++++++
 tb/tb_tipi_rpi_link.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tipi_rpi_link.sv
// Serial link master for the TIPI CPLD: shifts one byte to the RD/RC
// register or reads one byte from the TD/TC register per command.
module tipi_rpi_link #(
    parameter int HALF_PER = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       r_clk,
    output logic       r_le,
    output logic       r_rt,
    output logic       r_dc,
    output logic       r_dout,
    input  logic       r_din
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LE_HI,
        LE_LO,
        BIT_LO,
        BIT_HI,
        DONE
    } state_t;

    localparam logic [7:0] PH_LAST = 8'(HALF_PER - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] phase;
    logic [2:0] bit_cnt;
    logic       wr_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] rsp_q;
    logic       rt_q;
    logic       dc_q;
    logic       din_s1;
    logic       din_s2;
    logic       accept;
    logic       phase_end;
    logic       last_bit;

    assign accept    = cmd_valid && cmd_ready;
    assign phase_end = (phase == PH_LAST);
    assign last_bit  = (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) next_state = SETUP;
            end
            SETUP: begin
                if (phase_end) next_state = wr_q ? BIT_LO : LE_HI;
            end
            LE_HI: begin
                if (phase_end) next_state = LE_LO;
            end
            LE_LO: begin
                if (phase_end) next_state = wr_q ? DONE : BIT_LO;
            end
            BIT_LO: begin
                if (phase_end) next_state = BIT_HI;
            end
            BIT_HI: begin
                if (phase_end) begin
                    if (!last_bit)  next_state = BIT_LO;
                    else if (wr_q)  next_state = LE_HI;
                    else            next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = reset_n && (state == IDLE);
        busy      = (state != IDLE);
        rsp_valid = (state == DONE);
        r_le      = (state == LE_HI);
        r_clk     = (state == BIT_HI);
        r_rt      = rt_q;
        r_dc      = dc_q;
        rsp_data  = rsp_q;
        r_dout    = 1'b0;
        // bit_cnt is 0 in SETUP, so the MSB is already presented there
        if (wr_q && (state inside {SETUP, BIT_LO, BIT_HI})) begin
            r_dout = tx_q[3'd7 - bit_cnt];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
        end else begin
            din_s1 <= r_din;
            din_s2 <= din_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase   <= 8'd0;
            bit_cnt <= 3'd0;
            wr_q    <= 1'b0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            rsp_q   <= 8'd0;
            rt_q    <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= cmd_write;
                tx_q    <= cmd_wdata;
                rt_q    <= ~cmd_write;
                dc_q    <= cmd_sel;
                bit_cnt <= 3'd0;
            end

            if (state == IDLE || state == DONE) begin
                phase <= 8'd0;
            end else if (phase_end) begin
                phase <= 8'd0;
            end else begin
                phase <= phase + 8'd1;
            end

            if (state == BIT_HI && phase_end && !last_bit) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state == BIT_LO && phase_end) begin
                rx_q <= {rx_q[6:0], din_s2};
            end

            // load on entry to DONE so the byte is visible with rsp_valid
            if (state == BIT_HI && phase_end && last_bit && !wr_q) begin
                rsp_q <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_tipi_rpi_link.sv
// Randomised bench for tipi_rpi_link: two instances (HALF_PER 4 and 3)
// driven against a behavioural CPLD model and a response scoreboard.
module tb_tipi_rpi_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       cmd_valid [2];
    logic       cmd_write [2];
    logic       cmd_sel   [2];
    logic [7:0] cmd_wdata [2];
    logic       cmd_ready [2];
    logic       rsp_valid [2];
    logic [7:0] rsp_data  [2];
    logic       busy      [2];
    logic       r_clk     [2];
    logic       r_le      [2];
    logic       r_rt      [2];
    logic       r_dc      [2];
    logic       r_dout    [2];
    logic       r_din     [2];

    tipi_rpi_link #(.HALF_PER(4)) u_hp4 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_write(cmd_write[0]), .cmd_sel(cmd_sel[0]),
        .cmd_wdata(cmd_wdata[0]), .rsp_valid(rsp_valid[0]),
        .rsp_data(rsp_data[0]), .busy(busy[0]),
        .r_clk(r_clk[0]), .r_le(r_le[0]), .r_rt(r_rt[0]),
        .r_dc(r_dc[0]), .r_dout(r_dout[0]), .r_din(r_din[0])
    );

    tipi_rpi_link #(.HALF_PER(3)) u_hp3 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_write(cmd_write[1]), .cmd_sel(cmd_sel[1]),
        .cmd_wdata(cmd_wdata[1]), .rsp_valid(rsp_valid[1]),
        .rsp_data(rsp_data[1]), .busy(busy[1]),
        .r_clk(r_clk[1]), .r_le(r_le[1]), .r_rt(r_rt[1]),
        .r_dc(r_dc[1]), .r_dout(r_dout[1]), .r_din(r_din[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int hp(int i);
        return (i == 0) ? 4 : 3;
    endfunction

    // CPLD model and link monitor state
    logic [7:0] cpld_tx [2];
    logic [7:0] sh      [2];
    logic [7:0] wr_cap  [2];
    logic       p_clk   [2];
    logic       p_le    [2];
    logic       p_busy  [2];
    logic       p_rt    [2];
    logic       p_dc    [2];
    int         hi_run  [2];
    int         clk_cnt [2];
    int         le_cnt  [2];
    int         le_clk  [2];
    int         rv_cnt  [2];
    int         pulse_err [2];
    int         olap_err = 0;
    int         rtdc_err = 0;

    // scoreboard
    logic [7:0] rd_model [2];
    int         rv_exp   [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            clk_cnt[i] = 0; le_cnt[i] = 0; le_clk[i] = 0;
            rv_cnt[i] = 0; pulse_err[i] = 0; hi_run[i] = 0;
            sh[i] = 8'd0; wr_cap[i] = 8'd0; r_din[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                r_din[i]  = 1'b0;
                hi_run[i] = 0;
            end else begin
                if (r_clk[i] && r_le[i]) olap_err++;
                if (r_le[i] && !p_le[i]) begin
                    le_cnt[i]++;
                    le_clk[i] = clk_cnt[i];
                    sh[i]     = cpld_tx[i];
                    r_din[i]  = sh[i][7];
                end
                if (r_clk[i] && !p_clk[i]) begin
                    clk_cnt[i]++;
                    wr_cap[i] = {wr_cap[i][6:0], r_dout[i]};
                    hi_run[i] = 1;
                end else if (r_clk[i]) begin
                    hi_run[i]++;
                end else if (p_clk[i]) begin
                    if (hi_run[i] != hp(i)) pulse_err[i]++;
                    sh[i]    = sh[i] << 1;
                    r_din[i] = sh[i][7];
                end
                if (busy[i] && p_busy[i] &&
                    (r_rt[i] != p_rt[i] || r_dc[i] != p_dc[i]))
                    rtdc_err++;
                if (rsp_valid[i]) rv_cnt[i]++;
            end
            p_clk[i]  = reset_n ? r_clk[i] : 1'b0;
            p_le[i]   = reset_n ? r_le[i] : 1'b0;
            p_busy[i] = busy[i];
            p_rt[i]   = r_rt[i];
            p_dc[i]   = r_dc[i];
        end
    end

    task automatic wait_ready(int i);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready[i] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready", 32'(cmd_ready[i]), 32'd1);
    endtask

    task automatic do_cmd(int i, logic w, logic s, logic [7:0] d);
        int n;
        int b_clk;
        int b_le;
        logic [7:0] exp_rd;
        wait_ready(i);
        b_clk = clk_cnt[i];
        b_le  = le_cnt[i];
        exp_rd = w ? rd_model[i] : cpld_tx[i];
        cmd_valid[i] = 1'b1;
        cmd_write[i] = w;
        cmd_sel[i]   = s;
        cmd_wdata[i] = d;
        @(posedge clk);
        #1;
        cmd_valid[i] = 1'b0;
        cmd_write[i] = 1'($urandom);
        cmd_sel[i]   = 1'($urandom);
        cmd_wdata[i] = 8'($urandom);
        @(negedge clk);
        n = 1;
        chk("setup_busy", 32'(busy[i]), 32'd1);
        chk("setup_ready", 32'(cmd_ready[i]), 32'd0);
        chk("setup_rt", 32'(r_rt[i]), 32'(!w));
        chk("setup_dc", 32'(r_dc[i]), 32'(s));
        if (w) chk("setup_dout", 32'(r_dout[i]), 32'(d[7]));
        while (!rsp_valid[i] && n < 19 * hp(i) + 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(19 * hp(i) + 1));
        chk("rsp_data", 32'(rsp_data[i]), 32'(exp_rd));
        rd_model[i] = exp_rd;
        chk("done_rt", 32'(r_rt[i]), 32'(!w));
        chk("done_dc", 32'(r_dc[i]), 32'(s));
        chk("done_busy", 32'(busy[i]), 32'd1);
        chk("nclk", 32'(clk_cnt[i] - b_clk), 32'd8);
        chk("nle", 32'(le_cnt[i] - b_le), 32'd1);
        chk("le_order", 32'(le_clk[i] - b_clk), w ? 32'd8 : 32'd0);
        if (w) chk("wbyte", 32'(wr_cap[i]), 32'(d));
        rv_exp[i]++;
        @(negedge clk);
        chk("rv_pulse", 32'(rsp_valid[i]), 32'd0);
        chk("idle_ready", 32'(cmd_ready[i]), 32'd1);
        chk("idle_busy", 32'(busy[i]), 32'd0);
        chk("rsp_hold", 32'(rsp_data[i]), 32'(rd_model[i]));
    endtask

    task automatic b2b_test();
        int acc[$];
        int bad = 0;
        wait_ready(0);
        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_sel[0]   = 1'b0;
        cmd_wdata[0] = 8'($urandom);
        for (int c = 0; c < 4 * 78; c++) begin
            if (c > 0) @(negedge clk);
            if (cmd_valid[0] && cmd_ready[0]) acc.push_back(c);
            if (busy[0] && cmd_ready[0]) bad++;
        end
        cmd_valid[0] = 1'b0;
        repeat (100) @(negedge clk);
        chk("b2b_count", 32'(acc.size()), 32'd4);
        for (int k = 1; k < acc.size(); k++)
            chk("b2b_space", 32'(acc[k] - acc[k-1]), 32'd78);
        chk("b2b_ready", 32'(bad), 32'd0);
        rv_exp[0] += acc.size();
    endtask

    task automatic reset_test();
        int b_clk;
        int b_rv;
        int n = 0;
        wait_ready(0);
        b_clk = clk_cnt[0];
        cmd_valid[0] = 1'b1;
        cmd_write[0] = 1'b1;
        cmd_sel[0]   = 1'b1;
        cmd_wdata[0] = 8'hFF;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        while (!(clk_cnt[0] - b_clk == 4 && !r_clk[0]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", 32'(clk_cnt[0] - b_clk), 32'd4);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_clk", 32'(r_clk[0]), 32'd0);
        chk("rst_le", 32'(r_le[0]), 32'd0);
        chk("rst_dout", 32'(r_dout[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_rt", 32'(r_rt[0]), 32'd0);
        chk("rst_dc", 32'(r_dc[0]), 32'd0);
        chk("rst_ready", 32'(cmd_ready[0]), 32'd0);
        chk("rst_rdata", 32'(rsp_data[1]), 32'd0);
        rd_model[0] = 8'd0;
        rd_model[1] = 8'd0;
        @(negedge clk);
        reset_n = 1'b1;
        b_rv = rv_cnt[0];
        @(negedge clk);
        chk("rel_ready", 32'(cmd_ready[0]), 32'd1);
        repeat (100) @(negedge clk);
        chk("abort_rv", 32'(rv_cnt[0] - b_rv), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b1;
            cmd_write[i] = 1'b0;
            cmd_sel[i]   = 1'b0;
            cmd_wdata[i] = 8'd0;
            cpld_tx[i]   = 8'($urandom);
            rd_model[i]  = 8'd0;
            rv_exp[i]    = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("por_ready", 32'(cmd_ready[i]), 32'd0);
            chk("por_busy", 32'(busy[i]), 32'd0);
            chk("por_rdata", 32'(rsp_data[i]), 32'd0);
            chk("por_link", 32'({r_clk[i], r_le[i], r_rt[i],
                                 r_dc[i], r_dout[i]}), 32'd0);
            cmd_valid[i] = 1'b0;
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ready0", 32'(cmd_ready[0]), 32'd1);

        do_cmd(0, 1'b1, 1'b0, 8'hA5);
        cpld_tx[0] = 8'h3C;
        do_cmd(0, 1'b0, 1'b1, 8'h00);
        do_cmd(0, 1'b1, 1'b0, 8'($urandom));
        cpld_tx[1] = 8'hFF;
        do_cmd(1, 1'b0, 1'b0, 8'h00);
        cpld_tx[1] = 8'h00;
        do_cmd(1, 1'b0, 1'b1, 8'h00);

        b2b_test();
        reset_test();
        do_cmd(0, 1'b1, 1'b1, 8'h5A);

        for (int k = 0; k < 16; k++) begin
            int i;
            i = int'($urandom_range(0, 1));
            cpld_tx[i] = 8'($urandom);
            do_cmd(i, 1'($urandom), 1'($urandom), 8'($urandom));
        end

        repeat (5) @(negedge clk);
        chk("overlap", 32'(olap_err), 32'd0);
        chk("rtdc_stable", 32'(rtdc_err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("clk_width", 32'(pulse_err[i]), 32'd0);
            chk("rv_total", 32'(rv_cnt[i]), 32'(rv_exp[i]));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
